fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of instruction_memory: owns the program counter and drives the memory word address.
- Captures the combinationally-read instruction word into an IF/ID output register and hands it to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump) with flush, and faults on misaligned or out-of-range PCs.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction_memory combinationally
// and presents the captured word to decode through a valid/ready IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_rst_n,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc_plus4_q, out_pc_plus4_d;
  logic [1:0]  fault_cause_q, fault_cause_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic handshake;
  logic in_range;
  logic advance;

  assign handshake = out_valid_q & out_ready;
  assign in_range  = {2'b00, pc_q[31:2]} < IMEM_WORDS;
  assign advance   = (state_q == RUN) & (~out_valid_q | out_ready) & in_range;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_pc_d       = out_pc_q;
    out_pc_plus4_d = out_pc_plus4_q;
    fault_cause_d  = fault_cause_q;
    fault_pc_d     = fault_pc_q;
    // Decode consumed the word even when a redirect flushes the register this cycle.
    fetch_count_d  = fetch_count_q + {31'b0, handshake};

    case (state_q)
      RUN: begin
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          state_d       = FAULT;
          fault_cause_d = 2'b01;
          fault_pc_d    = redirect_pc;
          out_valid_d   = 1'b0;
        end else if (redirect_valid) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
        end else if (!in_range) begin
          state_d       = FAULT;
          fault_cause_d = 2'b10;
          fault_pc_d    = pc_q;
          if (out_ready) out_valid_d = 1'b0;
        end else if (advance) begin
          out_instr_d    = imem_rdata;
          out_pc_d       = pc_q;
          out_pc_plus4_d = pc_q + 32'd4;
          out_valid_d    = 1'b1;
          pc_d           = pc_q + 32'd4;
        end
      end
      FAULT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= '0;
      out_pc_plus4_q <= '0;
      fault_cause_q  <= '0;
      fault_pc_q     <= '0;
      fetch_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_pc_q       <= out_pc_d;
      out_pc_plus4_q <= out_pc_plus4_d;
      fault_cause_q  <= fault_cause_d;
      fault_pc_q     <= fault_pc_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign imem_rst_n   = ~rst;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_pc_plus4 = out_pc_plus4_q;
  assign fault        = (state_q == FAULT);
  assign fault_cause  = fault_cause_q;
  assign fault_pc     = fault_pc_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a full-size and a 4-word instance share stimulus and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;

  logic [31:0] mem [0:1023];

  logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_p4, b_fpc, b_cnt;
  logic        b_rst_n, b_valid, b_fault;
  logic [1:0]  b_cause;
  logic [31:0] s_addr, s_rdata, s_instr, s_pc, s_p4, s_fpc, s_cnt;
  logic        s_rst_n, s_valid, s_fault;
  logic [1:0]  s_cause;

  int checks = 0;
  int errors = 0;

  assign b_rdata = mem[b_addr[11:2]];
  assign s_rdata = mem[s_addr[11:2]];

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut_big (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_rst_n(b_rst_n), .imem_rdata(b_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(b_valid), .out_ready(out_ready), .out_instr(b_instr), .out_pc(b_pc),
    .out_pc_plus4(b_p4), .fault(b_fault), .fault_cause(b_cause), .fault_pc(b_fpc),
    .fetch_count(b_cnt));

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
    .clk(clk), .rst(rst), .imem_addr(s_addr), .imem_rst_n(s_rst_n), .imem_rdata(s_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(s_valid), .out_ready(out_ready), .out_instr(s_instr), .out_pc(s_pc),
    .out_pc_plus4(s_p4), .fault(s_fault), .fault_cause(s_cause), .fault_pc(s_fpc),
    .fetch_count(s_cnt));

  always #5 clk = ~clk;

  // Model: what decode should see, the next PC to fetch, and whether the stage has died.
  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        dead;
    logic [1:0]  cause;
    logic [31:0] fpc;
    logic [31:0] count;
  } model_t;

  model_t mb, ms;

  function automatic model_t model_reset();
    model_t m;
    m = '0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic rdy, logic rv, logic [31:0] rpc,
                                        longint unsigned words);
    model_t n;
    n = m;
    if (m.valid && rdy) n.count = m.count + 1;
    if (m.dead) begin
      if (rdy) n.valid = 1'b0;
    end else if (rv && (rpc % 4 != 0)) begin
      n.dead = 1'b1; n.cause = 2'd1; n.fpc = rpc; n.valid = 1'b0;
    end else if (rv) begin
      n.pc = rpc; n.valid = 1'b0;
    end else if (longint'(m.pc) / 4 >= words) begin
      n.dead = 1'b1; n.cause = 2'd2; n.fpc = m.pc;
      if (rdy) n.valid = 1'b0;
    end else if (!m.valid || rdy) begin
      n.valid = 1'b1;
      n.instr = mem[m.pc / 4];
      n.ipc   = m.pc;
      n.pc    = m.pc + 4;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb <= model_reset();
      ms <= model_reset();
    end else begin
      mb <= model_step(mb, out_ready, redirect_valid, redirect_pc, 1024);
      ms <= model_step(ms, out_ready, redirect_valid, redirect_pc, 4);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp(input string t, input model_t m, input logic [31:0] addr, input logic rn,
                     input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] p4, input logic f, input logic [1:0] fc,
                     input logic [31:0] fpc, input logic [31:0] cnt);
    chk({t, ".imem_addr"}, addr, m.pc);
    chk({t, ".imem_rst_n"}, 32'(rn), 32'd1);
    chk({t, ".out_valid"}, 32'(v), 32'(m.valid));
    if (m.valid) begin
      chk({t, ".out_instr"}, ins, m.instr);
      chk({t, ".out_pc"}, pc, m.ipc);
      chk({t, ".out_pc_plus4"}, p4, m.ipc + 32'd4);
    end
    chk({t, ".fault"}, 32'(f), 32'(m.dead));
    chk({t, ".fault_cause"}, 32'(fc), 32'(m.cause));
    chk({t, ".fault_pc"}, fpc, m.fpc);
    chk({t, ".fetch_count"}, cnt, m.count);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp("big", mb, b_addr, b_rst_n, b_valid, b_instr, b_pc, b_p4, b_fault, b_cause, b_fpc, b_cnt);
      cmp("small", ms, s_addr, s_rst_n, s_valid, s_instr, s_pc, s_p4, s_fault, s_cause, s_fpc, s_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h0064A423;
    mem[1] = 32'h00000013;

    step();
    step();
    chk("rst.out_valid", 32'(b_valid), 32'd0);
    chk("rst.imem_addr", b_addr, 32'h0);
    chk("rst.fetch_count", b_cnt, 32'd0);
    chk("rst.out_instr", b_instr, 32'd0);
    chk("rst.imem_rst_n", 32'(b_rst_n), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Back-to-back fetch
    step();
    chk("t1.valid", 32'(b_valid), 32'd1);
    chk("t1.instr0", b_instr, 32'h0064A423);
    chk("t1.pc0", b_pc, 32'h0);
    chk("t1.p4_0", b_p4, 32'h4);
    step();
    chk("t1.instr1", b_instr, 32'h00000013);
    chk("t1.pc1", b_pc, 32'h4);
    step();
    chk("t1.count", b_cnt, 32'd2);

    // Stall holds the IF/ID register and the PC
    do_reset();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2.stall_instr", b_instr, 32'h0064A423);
      chk("t2.stall_pc", b_pc, 32'h0);
      chk("t2.stall_addr", b_addr, 32'h4);
      chk("t2.stall_count", b_cnt, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t2.release_pc", b_pc, 32'h4);
    chk("t2.release_instr", b_instr, 32'h00000013);
    chk("t2.release_count", b_cnt, 32'd1);

    // Aligned redirect flushes the held instruction
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("t3.flush_valid", 32'(b_valid), 32'd0);
    chk("t3.addr", b_addr, 32'h40);
    chk("t3.count", b_cnt, 32'd2);
    step();
    chk("t3.valid", 32'(b_valid), 32'd1);
    chk("t3.pc", b_pc, 32'h40);
    chk("t3.instr", b_instr, mem[16]);

    // Misaligned redirect faults; later redirects are ignored
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    chk("t4.fault", 32'(b_fault), 32'd1);
    chk("t4.cause", 32'(b_cause), 32'd1);
    chk("t4.fault_pc", b_fpc, 32'h42);
    chk("t4.valid", 32'(b_valid), 32'd0);
    chk("t4.addr", b_addr, 32'h44);
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("t4.frozen_addr", b_addr, 32'h44);
    chk("t4.sticky_cause", 32'(b_cause), 32'd1);
    do_reset();
    chk("t4.rst_fault", 32'(b_fault), 32'd0);
    chk("t4.rst_cause", 32'(b_cause), 32'd0);
    chk("t4.rst_fault_pc", b_fpc, 32'd0);

    // Out-of-range fault on the 4-word instance
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5.pc", s_pc, 32'(i * 4));
      chk("t5.instr", s_instr, mem[i]);
    end
    step();
    chk("t5.fault", 32'(s_fault), 32'd1);
    chk("t5.cause", 32'(s_cause), 32'd2);
    chk("t5.fault_pc", s_fpc, 32'h10);
    chk("t5.count", s_cnt, 32'd4);
    chk("t5.valid", 32'(s_valid), 32'd0);

    // Asynchronous reset between edges
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("t6.addr", b_addr, 32'h20);
    chk("t6.valid", 32'(b_valid), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6.async_valid", 32'(b_valid), 32'd0);
    chk("t6.async_addr", b_addr, 32'h0);
    chk("t6.async_count", b_cnt, 32'd0);
    chk("t6.async_pc", b_pc, 32'd0);
    chk("t6.async_rst_n", 32'(b_rst_n), 32'd0);
    rst = 1'b0;
    step();
    chk("t6.restart_pc", b_pc, 32'h0);
    chk("t6.restart_instr", b_instr, 32'h0064A423);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom % 100) == 0;
      out_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc = 32'($urandom_range(0, 1100)) << 2;
      if (($urandom % 8) == 0) redirect_pc = redirect_pc | 32'($urandom_range(1, 3));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
